// File: rtl/sem_pkg.sv
// Shared definitions for the pedestrian-request front end: FSM states,
// counter width and the default amber start value.
package sem_pkg;

    localparam int SEM_W = 6;
    localparam logic [SEM_W-1:0] SEM_SALTO_DEF = 6'd30;

    typedef enum logic [2:0] {
        REPOSO,
        ESPERA,
        CARGA,
        BLOQUEO,
        FIN
    } sem_pet_t;

endpackage

// File: rtl/sem_antirrebote.sv
// Push-button conditioning: two-flop synchroniser, level debouncer and a
// single-cycle pulse when the debounced level goes from released to pressed.
module sem_antirrebote #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_n,
    output logic pulsa
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          estable;
    logic          estable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            estable   <= 1'b1;
            estable_d <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1     <= KEY_n;
            sync2     <= sync1;
            estable_d <= estable;
            // The level must differ for DEB_CYCLES consecutive cycles to be taken.
            if (sync2 != estable) begin
                if (cnt == CW'(DEB_CYCLES - 1)) begin
                    estable <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pulsa = estable_d & ~estable;

endmodule

// File: rtl/sem_peticion.sv
// Pedestrian-request front end: 1 s enable prescaler, car-green timer and the
// request FSM that shortens car green by loading the amber start value.
module sem_peticion
    import sem_pkg::*;
#(
    parameter int               DIV        = 50_000_000,
    parameter int               DEB_CYCLES = 1_000_000,
    parameter int               MIN_VERDE  = 10,
    parameter logic [SEM_W-1:0] SALTO      = SEM_SALTO_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             KEY_PEATONn,
    input  logic             Gcars,
    input  logic             Rcars,
    output logic             CLK_ENA,
    output logic             SEM_LOADn,
    output logic [SEM_W-1:0] SEM_P,
    output logic             PETICION
);

    localparam int PRE_W = $clog2(DIV);
    localparam int TV_W  = $clog2(MIN_VERDE + 1);

    logic [PRE_W-1:0] pre;
    logic             pre_tick;
    logic             pulsa;
    logic             verde;
    logic [TV_W-1:0]  t_verde;
    sem_pet_t         est;
    sem_pet_t         nxt;

    sem_antirrebote #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_antirrebote (
        .CLK  (CLK),
        .RST  (RST),
        .KEY_n(KEY_PEATONn),
        .pulsa(pulsa)
    );

    // pre_tick precedes the registered CLK_ENA by one cycle so a load decided
    // on it lands exactly on the enable cycle.
    assign pre_tick = (pre == PRE_W'(DIV - 2));
    assign verde    = Gcars & ~Rcars;
    assign SEM_P    = SALTO;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre     <= '0;
            CLK_ENA <= 1'b0;
            t_verde <= '0;
        end else begin
            pre     <= (pre == PRE_W'(DIV - 1)) ? '0 : pre + 1'b1;
            CLK_ENA <= pre_tick;
            if (!verde) begin
                t_verde <= '0;
            end else if (CLK_ENA && (t_verde < TV_W'(MIN_VERDE))) begin
                t_verde <= t_verde + 1'b1;
            end
        end
    end

    always_comb begin
        nxt = est;
        case (est)
            REPOSO:  if (pulsa && verde) nxt = ESPERA;
            ESPERA: begin
                // Natural amber wins over a load decided in the same cycle.
                if (!verde) begin
                    nxt = BLOQUEO;
                end else if (pre_tick && (t_verde >= TV_W'(MIN_VERDE))) begin
                    nxt = CARGA;
                end
            end
            CARGA:   nxt = BLOQUEO;
            BLOQUEO: if (!verde) nxt = FIN;
            FIN:     if (verde) nxt = REPOSO;
            default: nxt = REPOSO;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            est       <= REPOSO;
            PETICION  <= 1'b0;
            SEM_LOADn <= 1'b1;
        end else begin
            est       <= nxt;
            PETICION  <= (nxt == ESPERA) || (nxt == CARGA) || (nxt == BLOQUEO);
            SEM_LOADn <= (nxt != CARGA);
        end
    end

endmodule

// File: tb/tb_sem_peticion.sv
// Bench for sem_peticion: directed scenarios plus random button/phase activity,
// all checked every cycle against a behavioural request model.
module tb_sem_peticion;

    localparam int DIV        = 4;
    localparam int DEB_CYCLES = 3;
    localparam int MIN_VERDE  = 2;
    localparam logic [5:0] SALTO_EXP = 6'd30;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_LOAD = 2;
    localparam int M_HOLD = 3;
    localparam int M_DONE = 4;

    logic       CLK;
    logic       RST;
    logic       KEY_PEATONn;
    logic       Gcars;
    logic       Rcars;
    logic       CLK_ENA;
    logic       SEM_LOADn;
    logic [5:0] SEM_P;
    logic       PETICION;

    int n_cmp = 0;
    int n_bad = 0;
    int loads = 0;

    sem_peticion #(
        .DIV       (DIV),
        .DEB_CYCLES(DEB_CYCLES),
        .MIN_VERDE (MIN_VERDE)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .KEY_PEATONn(KEY_PEATONn),
        .Gcars      (Gcars),
        .Rcars      (Rcars),
        .CLK_ENA    (CLK_ENA),
        .SEM_LOADn  (SEM_LOADn),
        .SEM_P      (SEM_P),
        .PETICION   (PETICION)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural reference: cycles since reset, pin history, debounced level,
    // green-tick count and the request lifecycle.
    int   m_n = 0;
    int   m_run = 0;
    int   m_tv = 0;
    int   m_mode = M_IDLE;
    logic m_d1 = 1'b1, m_d2 = 1'b1;
    logic m_stable = 1'b1, m_stable_prev = 1'b1;
    logic m_ena = 1'b0, m_ld = 1'b1, m_pet = 1'b0;

    always @(posedge CLK) begin : model
        logic verde, pulse, tick;
        if (RST) begin
            m_n = 0; m_run = 0; m_tv = 0; m_mode = M_IDLE;
            m_d1 = 1'b1; m_d2 = 1'b1; m_stable = 1'b1; m_stable_prev = 1'b1;
            m_ena = 1'b0;
        end else begin
            verde = Gcars && !Rcars;
            pulse = m_stable_prev && !m_stable;
            tick  = (m_n % DIV) == DIV - 2;
            case (m_mode)
                M_IDLE: if (pulse && verde) m_mode = M_WAIT;
                M_WAIT: begin
                    if (!verde) m_mode = M_HOLD;
                    else if (tick && m_tv >= MIN_VERDE) m_mode = M_LOAD;
                end
                M_LOAD: m_mode = M_HOLD;
                M_HOLD: if (!verde) m_mode = M_DONE;
                default: if (verde) m_mode = M_IDLE;
            endcase
            if (!verde) m_tv = 0;
            else if (m_ena && m_tv < MIN_VERDE) m_tv = m_tv + 1;
            m_ena = tick;
            m_n   = m_n + 1;
            m_stable_prev = m_stable;
            if (m_d2 != m_stable) begin
                m_run = m_run + 1;
                if (m_run == DEB_CYCLES) begin
                    m_stable = m_d2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_d2 = m_d1;
            m_d1 = KEY_PEATONn;
        end
        m_pet = (m_mode == M_WAIT) || (m_mode == M_LOAD) || (m_mode == M_HOLD);
        m_ld  = (m_mode != M_LOAD);
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        chk1("CLK_ENA", CLK_ENA, m_ena);
        chk1("SEM_LOADn", SEM_LOADn, m_ld);
        chk1("PETICION", PETICION, m_pet);
        chk6("SEM_P", SEM_P, SALTO_EXP);
        if (SEM_LOADn === 1'b0) loads++;
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    initial begin : stim
        bit found;
        RST = 1'b1; KEY_PEATONn = 1'b1; Gcars = 1'b0; Rcars = 1'b1;

        // Reset held 3 cycles, then enable ticks at cycles 4, 8, 12.
        repeat (3) @(posedge CLK);
        step();
        RST = 1'b0;
        for (int k = 2; k <= 13; k++) begin
            step();
            chk1("tick_cycle", CLK_ENA, (k % 4) == 0);
        end

        // Bounce rejection with cars green, then a clean press.
        Gcars = 1'b1; Rcars = 1'b0;
        steps(4);
        for (int i = 0; i < 10; i++) begin
            KEY_PEATONn = ~KEY_PEATONn;
            steps(2);
            chk1("bounce_pet", PETICION, 1'b0);
        end
        KEY_PEATONn = 1'b0;
        steps(5);
        chk1("press_lat5", PETICION, 1'b0);
        step();
        chk1("press_lat6", PETICION, 1'b1);
        steps(10);
        KEY_PEATONn = 1'b1;
        Gcars = 1'b0; Rcars = 1'b1;
        steps(6);
        Gcars = 1'b1; Rcars = 1'b0;
        steps(4);

        // Min green held: press as green starts, exactly one load expected.
        Gcars = 1'b0; Rcars = 1'b1;
        steps(6);
        loads = 0;
        Gcars = 1'b1; Rcars = 1'b0; KEY_PEATONn = 1'b0;
        steps(24);
        chki("min_green_loads", loads, 1);
        KEY_PEATONn = 1'b1;
        Gcars = 1'b0; Rcars = 1'b1;
        steps(4);
        chk1("min_green_clear", PETICION, 1'b0);
        Gcars = 1'b1; Rcars = 1'b0;
        steps(4);

        // Press during amber is dropped.
        loads = 0;
        Gcars = 1'b1; Rcars = 1'b1; KEY_PEATONn = 1'b0;
        steps(12);
        KEY_PEATONn = 1'b1;
        steps(8);
        chki("amber_press_loads", loads, 0);
        chk1("amber_press_pet", PETICION, 1'b0);

        // Natural amber on the very pre_tick that would have loaded.
        Gcars = 1'b0; Rcars = 1'b1;
        steps(3);
        Gcars = 1'b1; Rcars = 1'b0; KEY_PEATONn = 1'b0;
        found = 1'b0;
        loads = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (m_mode == M_WAIT && m_tv >= MIN_VERDE && (m_n % DIV) == DIV - 2) begin
                Gcars = 1'b0; Rcars = 1'b1;
                found = 1'b1;
            end
        end
        chk1("amber_race_found", found, 1'b1);
        step();
        chk1("amber_race_bloq", PETICION, 1'b1);
        step();
        chk1("amber_race_fin", PETICION, 1'b0);
        steps(4);
        chki("amber_race_loads", loads, 0);
        KEY_PEATONn = 1'b1;
        steps(6);
        Gcars = 1'b1; Rcars = 1'b0;
        steps(4);

        // Reset while a request waits in ESPERA.
        Gcars = 1'b0; Rcars = 1'b1;
        steps(2);
        Gcars = 1'b1; Rcars = 1'b0; KEY_PEATONn = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (m_mode == M_WAIT) found = 1'b1;
        end
        chk1("rst_mid_found", found, 1'b1);
        chk1("rst_mid_pending", PETICION, 1'b1);
        RST = 1'b1; KEY_PEATONn = 1'b1;
        step();
        chk1("rst_mid_pet", PETICION, 1'b0);
        chk1("rst_mid_ld", SEM_LOADn, 1'b1);
        RST = 1'b0;
        loads = 0;
        steps(20);
        chki("rst_mid_loads", loads, 0);

        // Random button activity and car phases.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) KEY_PEATONn = ~KEY_PEATONn;
            if ($urandom_range(0, 24) == 0) begin
                Gcars = 1'($urandom_range(0, 1));
                Rcars = 1'($urandom_range(0, 1));
            end
            RST = ($urandom_range(0, 249) == 0);
            step();
        end
        RST = 1'b0;
        steps(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
